// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes engine: substitutes a 16-byte block LANES bytes per cycle
// behind a valid/ready handshake on both sides.
module sub_bytes_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] inputData,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outData,
  output logic         busy
);

  localparam int unsigned NCHUNK = 16 / LANES;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) || (LANES == 16))) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must divide 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] s;
    s = gf_inv(b);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [127:0]      r_data;
  logic              r_mode;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  int                w_base;
  logic [127:0]      w_data_nxt;
  logic [LANES-1:0][7:0] w_in;
  logic [LANES-1:0][7:0] w_fwd;
  logic [LANES-1:0][7:0] w_inv;
  logic [LANES-1:0][7:0] w_sub;

  assign w_base = int'(r_cnt) * int'(LANES);
  assign w_last = (r_cnt == CW'(NCHUNK - 1));

  // One forward and one inverse S-box per lane, muxed by the captured mode
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    assign w_in[l]  = r_data[(w_base + l) * 8 +: 8];
    assign w_fwd[l] = sbox_fwd(w_in[l]);
    assign w_inv[l] = sbox_inv(w_in[l]);
    assign w_sub[l] = r_mode ? w_fwd[l] : w_inv[l];
  end

  always_comb begin
    w_data_nxt = r_data;
    for (int l = 0; l < int'(LANES); l++) begin
      w_data_nxt[(w_base + l) * 8 +: 8] = w_sub[l];
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= inputData;
        r_mode <= mode;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_data <= w_data_nxt;
        r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign outData = r_data;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: known S-box vectors, latency, backpressure,
// back-to-back transfer, mode capture, reset abort and forward/inverse round trips.
module tb_sub_bytes_engine;

  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid, in_valid_a;
  logic         out_ready, out_ready_a;
  logic         mode;
  logic [127:0] inputData;

  logic         in_ready4, out_valid4, busy4;
  logic [127:0] outData4;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] outData1;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] outData16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode),
    .inputData(inputData), .out_valid(out_valid4), .out_ready(out_ready),
    .outData(outData4), .busy(busy4)
  );

  sub_bytes_engine #(.LANES(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_a), .in_ready(in_ready1), .mode(mode),
    .inputData(inputData), .out_valid(out_valid1), .out_ready(out_ready_a),
    .outData(outData1), .busy(busy1)
  );

  sub_bytes_engine #(.LANES(16)) dut16 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_a), .in_ready(in_ready16), .mode(mode),
    .inputData(inputData), .out_valid(out_valid16), .out_ready(out_ready_a),
    .outData(outData16), .busy(busy16)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block to the main DUT; returns in the cycle after the transfer edge
  task automatic send(input logic [127:0] d, input logic m);
    in_valid  = 1'b1;
    inputData = d;
    mode      = m;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid4) check_eq({tag, "_timeout"}, 128'(out_valid4), 128'd1);
  endtask

  task automatic run_block(input logic [127:0] d, input logic m, input logic [127:0] exp,
                           input string tag);
    send(d, m);
    check_eq({tag, "_busy"}, 128'(busy4), 128'd1);
    for (int i = 1; i <= NCH; i++) begin
      @(negedge clk);
      if (i == NCH - 1) check_eq({tag, "_early"}, 128'(out_valid4), 128'd0);
    end
    check_eq({tag, "_valid"}, 128'(out_valid4), 128'd1);
    check_eq({tag, "_data"}, outData4, exp);
    consume();
  endtask

  logic [127:0] ord_in, ord_exp, x, y;
  logic         seen;

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_valid_a = 1'b0;
    out_ready = 1'b0; out_ready_a = 1'b0; mode = 1'b0; inputData = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready4), 128'd1);
    check_eq("rst_out_valid", 128'(out_valid4), 128'd0);
    check_eq("rst_busy", 128'(busy4), 128'd0);
    check_eq("rst_outData", outData4, 128'd0);
    n_rst = 1'b1;
    @(negedge clk);

    run_block(128'd0, 1'b1, {16{8'h63}}, "fwd_zero");
    run_block({16{8'h63}}, 1'b0, 128'd0, "inv_63");
    run_block(128'd0, 1'b0, {16{8'h52}}, "inv_zero");

    // Byte ordering on LANES = 4, 1 and 16 in parallel
    ord_in  = 128'h0f0e0d0c0b0a09080706050403020100;
    ord_exp = 128'h76abd7fe2b670130c56f6bf27b777c63;
    in_valid = 1'b1; in_valid_a = 1'b1; inputData = ord_in; mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1)  check_eq("ord16_lat", 128'(out_valid16), 128'd1);
      if (i == 15) check_eq("ord1_early", 128'(out_valid1), 128'd0);
      if (i == 16) check_eq("ord1_lat", 128'(out_valid1), 128'd1);
    end
    check_eq("ord4_data", outData4, ord_exp);
    check_eq("ord1_data", outData1, ord_exp);
    check_eq("ord16_data", outData16, ord_exp);
    out_ready = 1'b1; out_ready_a = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready_a = 1'b0;

    // Backpressure then back-to-back transfer
    send(128'd0, 1'b1);
    repeat (NCH) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_data", outData4, {16{8'h63}});
      check_eq("bp_in_ready", 128'(in_ready4), 128'd0);
      @(negedge clk);
    end
    check_eq("bp_hold_valid", 128'(out_valid4), 128'd1);
    out_ready = 1'b1; in_valid = 1'b1; inputData = {16{8'h63}}; mode = 1'b0;
    #1 check_eq("b2b_in_ready", 128'(in_ready4), 128'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq("b2b_busy", 128'(busy4), 128'd1);
    check_eq("b2b_out_valid", 128'(out_valid4), 128'd0);
    for (int i = 1; i <= NCH; i++) @(negedge clk);
    check_eq("b2b_valid", 128'(out_valid4), 128'd1);
    check_eq("b2b_data", outData4, 128'd0);
    consume();

    // Input changes while busy must not affect the captured block
    send(128'd0, 1'b1);
    mode = 1'b0; inputData = '1;
    repeat (NCH) @(negedge clk);
    check_eq("mode_valid", 128'(out_valid4), 128'd1);
    check_eq("mode_data", outData4, {16{8'h63}});
    consume();

    // Reset mid-BUSY discards the block; no accept while in reset
    send(128'h0123456789abcdef0011223344556677, 1'b1);
    @(negedge clk);
    n_rst = 1'b0; in_valid = 1'b1; inputData = 128'hdeadbeef;
    @(negedge clk);
    check_eq("mrst_in_ready", 128'(in_ready4), 128'd1);
    check_eq("mrst_out_valid", 128'(out_valid4), 128'd0);
    check_eq("mrst_outData", outData4, 128'd0);
    check_eq("mrst_busy", 128'(busy4), 128'd0);
    n_rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("mrst_no_accept", 128'(busy4), 128'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid4;
    end
    check_eq("mrst_no_stale", 128'(seen), 128'd0);

    // Forward then inverse returns the original block
    for (int b = 0; b < 1000; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(x, 1'b1);
      wait_out("rt_fwd");
      y = outData4;
      consume();
      send(y, 1'b0);
      wait_out("rt_inv");
      check_eq("roundtrip", outData4, x);
      consume();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
